// File: rtl/ds2411_id_sequencer.sv
// DS2411 ROM-ID sequencer: launches read_ds2411, validates the family code (and the Dallas CRC-8
// when the DS2411_CRC_EN macro is defined), retries with a holdoff, and holds the last good ID.
module ds2411_id_sequencer #(
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned RETRY_GAP = 1000,
  parameter int unsigned TIMEOUT   = 200000,
  parameter logic [7:0]  FAMILY    = 8'h01
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        rd_go,
  input  logic        rd_done,
  input  logic        rd_error,
  input  logic [63:0] rd_result,
  output logic        busy,
  output logic        id_valid,
  output logic [47:0] id,
  output logic [7:0]  family,
  output logic        fail,
  output logic [3:0]  retry_cnt
);

  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GapW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT - 1);
  localparam logic [GapW-1:0] GapLast  = GapW'(RETRY_GAP - 1);
  localparam logic [3:0]      RetryMax = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    StIdle, StLaunch, StWait, StCheck, StAttFail, StGap, StValid, StFail
  } state_e;

  state_e            state_q, state_d;
  logic              auto_q, auto_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [63:0]       shadow_q, shadow_d;
  logic [47:0]       id_q, id_d;
  logic [7:0]        family_q, family_d;
  logic              id_valid_q, id_valid_d;
  logic              fail_q, fail_d;
  logic [3:0]        retry_q, retry_d;
  logic              check_done, check_ok, fam_ok;

`ifdef DS2411_CRC_EN
  logic [7:0]        crc_q, crc_d, crc_next;
  logic [5:0]        bit_q, bit_d;
  logic              crc_fb;
`else
  logic              unused_crc_byte;
  assign unused_crc_byte = ^shadow_q[63:56];
`endif

  assign fam_ok = (shadow_q[7:0] == FAMILY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      auto_q     <= 1'b1;
      tmo_q      <= '0;
      gap_q      <= '0;
      shadow_q   <= '0;
      id_q       <= '0;
      family_q   <= '0;
      id_valid_q <= 1'b0;
      fail_q     <= 1'b0;
      retry_q    <= '0;
`ifdef DS2411_CRC_EN
      crc_q      <= '0;
      bit_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      auto_q     <= auto_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      shadow_q   <= shadow_d;
      id_q       <= id_d;
      family_q   <= family_d;
      id_valid_q <= id_valid_d;
      fail_q     <= fail_d;
      retry_q    <= retry_d;
`ifdef DS2411_CRC_EN
      crc_q      <= crc_d;
      bit_q      <= bit_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    auto_d     = auto_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    shadow_d   = shadow_q;
    id_d       = id_q;
    family_d   = family_q;
    id_valid_d = id_valid_q;
    fail_d     = fail_q;
    retry_d    = retry_q;
    rd_go      = 1'b0;
    check_done = 1'b0;
    check_ok   = 1'b0;
`ifdef DS2411_CRC_EN
    crc_d    = crc_q;
    bit_d    = bit_q;
    crc_fb   = crc_q[0] ^ shadow_q[bit_q];
    crc_next = {1'b0, crc_q[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
`endif

    unique case (state_q)
      StIdle: begin
        if (auto_q || start) begin
          state_d = StLaunch;
          auto_d  = 1'b0;
          retry_d = '0;
        end
      end
      StLaunch: begin
        rd_go   = 1'b1;
        tmo_d   = '0;
        state_d = StWait;
`ifdef DS2411_CRC_EN
        crc_d = '0;
        bit_d = '0;
`endif
      end
      StWait: begin
        tmo_d = tmo_q + 1'b1;
        if (rd_done && !rd_error) begin
          shadow_d = rd_result;
          state_d  = StCheck;
        end else if (rd_done || (tmo_q == TmoLast)) begin
          state_d = StAttFail;
        end
      end
      StCheck: begin
`ifdef DS2411_CRC_EN
        // One ROM bit per cycle, LSB first; the last bit's update feeds the compare.
        crc_d = crc_next;
        bit_d = bit_q + 6'd1;
        if (bit_q == 6'd55) begin
          check_done = 1'b1;
          check_ok   = fam_ok && (crc_next == shadow_q[63:56]);
        end
`else
        check_done = 1'b1;
        check_ok   = fam_ok;
`endif
        if (check_done) begin
          if (check_ok) begin
            state_d    = StValid;
            id_d       = shadow_q[55:8];
            family_d   = shadow_q[7:0];
            id_valid_d = 1'b1;
          end else begin
            state_d = StAttFail;
          end
        end
      end
      StAttFail: begin
        retry_d = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;
        gap_d   = '0;
        if (retry_q == RetryMax) begin
          state_d = StFail;
          fail_d  = 1'b1;
        end else begin
          state_d = StGap;
        end
      end
      StGap: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GapLast) state_d = StLaunch;
      end
      StValid, StFail: begin
        if (start) begin
          state_d = StLaunch;
          retry_d = '0;
          fail_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy      = !(state_q inside {StIdle, StValid, StFail});
  assign id_valid  = id_valid_q;
  assign id        = id_q;
  assign family    = family_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_ds2411_id_sequencer.sv
// Bench for ds2411_id_sequencer: a read_ds2411 response model plus a scoreboard of expected
// end-of-sequence results; define DS2411_CRC_EN on both files to exercise the CRC build.
module tb_ds2411_id_sequencer;

  localparam int unsigned MaxRetry = 3;
  localparam int unsigned RetryGap = 20;
  localparam int unsigned Timeout  = 100;

  logic        clk = 1'b0;
  logic        reset_n, start, rd_go, rd_done, rd_error;
  logic [63:0] rd_result;
  logic        busy, id_valid, fail;
  logic [47:0] id;
  logic [7:0]  family;
  logic [3:0]  retry_cnt;

  always #5 clk = ~clk;

  ds2411_id_sequencer #(
    .MAX_RETRY(MaxRetry),
    .RETRY_GAP(RetryGap),
    .TIMEOUT  (Timeout),
    .FAMILY   (8'h01)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .rd_go    (rd_go),
    .rd_done  (rd_done),
    .rd_error (rd_error),
    .rd_result(rd_result),
    .busy     (busy),
    .id_valid (id_valid),
    .id       (id),
    .family   (family),
    .fail     (fail),
    .retry_cnt(retry_cnt)
  );

  typedef struct {
    logic [61:0] vec;  // {id_valid, fail, retry_cnt, family, id}
    int          gos;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] rsp_res[$];
  bit          rsp_err[$];
  bit          rsp_sil[$];
  int          go_cyc[$];
  int          go_count = 0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference Dallas CRC-8 over {serial, family}, LSB first.
  function automatic logic [63:0] make_rom(input logic [47:0] ser, input logic [7:0] fam);
    logic [55:0] d;
    logic [7:0]  c;
    logic        fb;
    d = {ser, fam};
    c = 8'h00;
    for (int i = 0; i < 56; i++) begin
      fb = c[0] ^ d[i];
      c  = {1'b0, c[7:1]} ^ (fb ? 8'h8C : 8'h00);
    end
    return {c, d};
  endfunction

  // read_ds2411 model: answers each go 3 cycles later, or stays silent.
  initial begin
    logic [63:0] r;
    bit          e, s;
    rd_done = 1'b0; rd_error = 1'b0; rd_result = '0;
    forever begin
      @(posedge clk); #1;
      rd_done = 1'b0; rd_error = 1'b0;
      if (rd_go === 1'b1) begin
        go_count++;
        go_cyc.push_back(cyc);
        if (rsp_res.size() > 0) begin
          r = rsp_res.pop_front(); e = rsp_err.pop_front(); s = rsp_sil.pop_front();
        end else begin
          r = '0; e = 1'b0; s = 1'b1;
        end
        if (!s) begin
          repeat (3) @(posedge clk);
          #1;
          rd_result = r; rd_error = e; rd_done = 1'b1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic add_rsp(input logic [63:0] r, input bit e, input bit s);
    rsp_res.push_back(r); rsp_err.push_back(e); rsp_sil.push_back(s);
  endtask

  task automatic clear_rsp();
    rsp_res.delete(); rsp_err.delete(); rsp_sil.delete();
  endtask

  task automatic push_exp(input bit v, input bit f, input logic [3:0] rc, input logic [7:0] fam,
                          input logic [47:0] ser, input int gos);
    exp_t e;
    e.vec = {v, f, rc, fam, ser};
    e.gos = gos;
    sb_q.push_back(e);
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_seq(output bit ok);
    int n;
    ok = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (busy !== 1'b1) ok = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    if (busy !== 1'b0) ok = 1'b0;
  endtask

  task automatic test_reset();
    int  g0;
    bit  seen, ok;
    exp_t e;
    logic [63:0] rom;
    reset_n = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({rd_go, busy, id_valid, fail, retry_cnt, family, id} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, required 0",
               {rd_go, busy, id_valid, fail, retry_cnt, family, id});
    end
`ifdef DS2411_CRC_EN
    rom = make_rom(48'h0, 8'h01);
`else
    rom = 64'h3500_0000_0000_0001;
`endif
    clear_rsp();
    add_rsp(rom, 1'b0, 1'b0);
    push_exp(1'b1, 1'b0, 4'd0, 8'h01, 48'h0, 1);
    g0 = go_count;
    seen = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (rd_go === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL reset_go_latency: rd_go=0 within 2 cycles, required 1");
    end
    wait_seq(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL reset_seq_end: busy did not fall, required 0"); end
    e = sb_q.pop_front();
    total++;
    if ({id_valid, fail, retry_cnt, family, id} !== e.vec) begin
      bad++;
      $display("FAIL reset_result: got %h, required %h",
               {id_valid, fail, retry_cnt, family, id}, e.vec);
    end
    total++;
    if (go_count - g0 !== e.gos) begin
      bad++;
      $display("FAIL reset_go_count: got %0d, required %0d", go_count - g0, e.gos);
    end
  endtask

  task automatic test_bad_crc();
    int  g0, base;
    bit  ok;
    exp_t e;
    hold_reset();
    clear_rsp();
    for (int i = 0; i < 4; i++) add_rsp(64'h3400_0000_0000_0001, 1'b0, 1'b0);
`ifdef DS2411_CRC_EN
    push_exp(1'b0, 1'b1, 4'd4, 8'h00, 48'h0, 4);
`else
    push_exp(1'b1, 1'b0, 4'd0, 8'h01, 48'h0, 1);
`endif
    g0 = go_count;
    base = go_cyc.size();
    reset_n = 1'b1;
    wait_seq(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL crc_seq_end: busy did not fall, required 0"); end
    e = sb_q.pop_front();
    total++;
    if ({id_valid, fail, retry_cnt, family, id} !== e.vec) begin
      bad++;
      $display("FAIL crc_result: got %h, required %h",
               {id_valid, fail, retry_cnt, family, id}, e.vec);
    end
    total++;
    if (go_count - g0 !== e.gos) begin
      bad++;
      $display("FAIL crc_go_count: got %0d, required %0d", go_count - g0, e.gos);
    end
    for (int i = base + 1; i < go_cyc.size(); i++) begin
      total++;
      if (go_cyc[i] - go_cyc[i-1] < RetryGap) begin
        bad++;
        $display("FAIL crc_go_spacing: got %0d cycles, required >= %0d",
                 go_cyc[i] - go_cyc[i-1], RetryGap);
      end
    end
  endtask

  task automatic test_error_retry();
    int  g0;
    bit  ok;
    exp_t e;
    logic [47:0] ser;
    ser = 48'h1234_5678_9ABC;
    hold_reset();
    clear_rsp();
    add_rsp(make_rom(ser, 8'h01), 1'b1, 1'b0);
    add_rsp(make_rom(ser, 8'h01), 1'b0, 1'b0);
    push_exp(1'b1, 1'b0, 4'd1, 8'h01, ser, 2);
    g0 = go_count;
    reset_n = 1'b1;
    wait_seq(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL err_seq_end: busy did not fall, required 0"); end
    e = sb_q.pop_front();
    total++;
    if ({id_valid, fail, retry_cnt, family, id} !== e.vec) begin
      bad++;
      $display("FAIL err_result: got %h, required %h",
               {id_valid, fail, retry_cnt, family, id}, e.vec);
    end
    total++;
    if (go_count - g0 !== e.gos) begin
      bad++;
      $display("FAIL err_go_count: got %0d, required %0d", go_count - g0, e.gos);
    end
  endtask

  task automatic test_timeout();
    int  g0, base;
    bit  ok;
    exp_t e;
    hold_reset();
    clear_rsp();
    push_exp(1'b0, 1'b1, 4'd4, 8'h00, 48'h0, 4);
    g0 = go_count;
    base = go_cyc.size();
    reset_n = 1'b1;
    wait_seq(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL tmo_seq_end: busy did not fall, required 0"); end
    e = sb_q.pop_front();
    total++;
    if ({id_valid, fail, retry_cnt, family, id} !== e.vec) begin
      bad++;
      $display("FAIL tmo_result: got %h, required %h",
               {id_valid, fail, retry_cnt, family, id}, e.vec);
    end
    total++;
    if (go_count - g0 !== e.gos) begin
      bad++;
      $display("FAIL tmo_go_count: got %0d, required %0d", go_count - g0, e.gos);
    end
    // LAUNCH + TIMEOUT wait cycles + ATTEMPT_FAIL + RETRY_GAP
    for (int i = base + 1; i < go_cyc.size(); i++) begin
      total++;
      if (go_cyc[i] - go_cyc[i-1] != Timeout + RetryGap + 2) begin
        bad++;
        $display("FAIL tmo_go_spacing: got %0d cycles, required %0d",
                 go_cyc[i] - go_cyc[i-1], Timeout + RetryGap + 2);
      end
    end
  endtask

  task automatic test_reread_bad_family();
    int  g0;
    bit  ok;
    exp_t e;
    logic [47:0] ser;
    ser = 48'hCAFE_0000_BEEF;
    hold_reset();
    clear_rsp();
    add_rsp(make_rom(ser, 8'h01), 1'b0, 1'b0);
    reset_n = 1'b1;
    wait_seq(ok);
    clear_rsp();
    for (int i = 0; i < 4; i++) add_rsp(make_rom(48'h5555_AAAA_0F0F, 8'h28), 1'b0, 1'b0);
    push_exp(1'b1, 1'b1, 4'd4, 8'h01, ser, 4);
    g0 = go_count;
    pulse_start();
    repeat (3) @(negedge clk);
    total++;
    if ({busy, id_valid, id} !== {1'b1, 1'b1, ser}) begin
      bad++;
      $display("FAIL reread_hold: got %h, required %h", {busy, id_valid, id}, {1'b1, 1'b1, ser});
    end
    pulse_start();
    wait_seq(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL reread_seq_end: busy did not fall, required 0"); end
    e = sb_q.pop_front();
    total++;
    if ({id_valid, fail, retry_cnt, family, id} !== e.vec) begin
      bad++;
      $display("FAIL reread_result: got %h, required %h",
               {id_valid, fail, retry_cnt, family, id}, e.vec);
    end
    total++;
    if (go_count - g0 !== e.gos) begin
      bad++;
      $display("FAIL reread_go_count: got %0d, required %0d", go_count - g0, e.gos);
    end
  endtask

  task automatic test_reset_in_gap();
    int  g0, n;
    bit  ok, seen;
    exp_t e;
    logic [47:0] ser;
    ser = 48'h0102_0304_0506;
    clear_rsp();
    add_rsp(64'h0, 1'b1, 1'b0);
    pulse_start();
    n = 0;
    while (retry_cnt !== 4'd1 && n < 50) begin @(negedge clk); n++; end
    total++;
    if ({busy, retry_cnt} !== {1'b1, 4'd1}) begin
      bad++;
      $display("FAIL gap_reach: got busy/retry %h, required %h", {busy, retry_cnt}, 5'h11);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({rd_go, busy, id_valid, fail, retry_cnt, family, id} !== '0) begin
      bad++;
      $display("FAIL gap_reset_outputs: got %h, required 0",
               {rd_go, busy, id_valid, fail, retry_cnt, family, id});
    end
    repeat (2) @(negedge clk);
    clear_rsp();
    add_rsp(make_rom(ser, 8'h01), 1'b0, 1'b0);
    push_exp(1'b1, 1'b0, 4'd0, 8'h01, ser, 1);
    g0 = go_count;
    seen = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (rd_go === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL gap_go_latency: rd_go=0 within 2 cycles, required 1");
    end
    wait_seq(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL gap_seq_end: busy did not fall, required 0"); end
    e = sb_q.pop_front();
    total++;
    if ({id_valid, fail, retry_cnt, family, id} !== e.vec) begin
      bad++;
      $display("FAIL gap_result: got %h, required %h",
               {id_valid, fail, retry_cnt, family, id}, e.vec);
    end
    total++;
    if (go_count - g0 !== e.gos) begin
      bad++;
      $display("FAIL gap_go_count: got %0d, required %0d", go_count - g0, e.gos);
    end
  endtask

  initial begin
    test_reset();
    test_bad_crc();
    test_error_retry();
    test_timeout();
    test_reread_bad_family();
    test_reset_in_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
